// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - bus bundle between the I/D requesters, the memory port and the arbiter
//
// Purpose: carries both requester handshakes and the shared memory-port
// signals. The arbiter connects through the slave modport; the requesters
// and the memory model use the master modport.
// Signals:
//   i_read/i_write/i_addr/i_wdata  I-side request (level, held until i_ready)
//   i_rdata/i_ready                I-side read line and completion pulse
//   d_*                            same set for the D-side
//   mem_read/mem_write/mem_addr/mem_wdata  memory request, held through a transaction
//   mem_rdata/mem_ready            memory read line and one-cycle completion

interface mem_port_arbiter_if #(
  parameter int AW = 28,
  parameter int DW = 128
);
  logic          i_read;
  logic          i_write;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_wdata;
  logic [DW-1:0] i_rdata;
  logic          i_ready;

  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata,
    output i_rdata, i_ready,
    input  d_read, d_write, d_addr, d_wdata,
    output d_rdata, d_ready,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata,
    input  i_rdata, i_ready,
    output d_read, d_write, d_addr, d_wdata,
    input  d_rdata, d_ready,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - two-requester arbiter for a shared 128-bit line-fill memory port
//
// Purpose: latches one I-side or D-side request at a time, drives it onto the
// memory port until mem_ready, then returns the line and a one-cycle ready
// pulse to the owner. All outputs are registered.
// Ports:
//   clk      single clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mem_port_arbiter_if.slave (requester and memory handshakes)
//   busy     high whenever the FSM is not IDLE
//   grant    {d,i} one-hot owner of the current transaction, 00 in IDLE
// Build option: ARB_RR_EN selects round-robin tie-break (grant the side
// opposite the last owner); undefined gives fixed priority, D wins ties.

module mem_port_arbiter #(
  parameter int AW = 28,
  parameter int DW = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  mem_port_arbiter_if.slave   bus,
  output logic                busy,
  output logic [1:0]          grant
);

`ifdef ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t state;
  logic   owner_d;       // 1: D-side owns the current transaction
  logic   last_grant_i;  // 1: last completed owner was I; 0 (reset) means D

  logic          i_act;
  logic          d_act;
  logic          pick_d;
  logic          pick_write;
  logic [AW-1:0] pick_addr;
  logic [DW-1:0] pick_wdata;

  always_comb begin
    i_act = bus.i_read | bus.i_write;
    d_act = bus.d_read | bus.d_write;
    // On a tie, round-robin hands the port to the side that did not go last;
    // fixed priority always favours D.
    if (i_act && d_act) pick_d = RR_EN ? last_grant_i : 1'b1;
    else                pick_d = d_act;
    // read and write raised together are treated as a write.
    pick_write = pick_d ? bus.d_write : bus.i_write;
    pick_addr  = pick_d ? bus.d_addr  : bus.i_addr;
    pick_wdata = pick_d ? bus.d_wdata : bus.i_wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner_d       <= 1'b0;
      last_grant_i  <= 1'b0;
      busy          <= 1'b0;
      grant         <= 2'b00;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      bus.i_rdata   <= '0;
      bus.d_rdata   <= '0;
      bus.i_ready   <= 1'b0;
      bus.d_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_act || d_act) begin
            owner_d       <= pick_d;
            bus.mem_addr  <= pick_addr;
            bus.mem_wdata <= pick_wdata;
            bus.mem_write <= pick_write;
            bus.mem_read  <= ~pick_write;
            grant         <= pick_d ? 2'b10 : 2'b01;
            busy          <= 1'b1;
            state         <= BUSY;
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            // mem_read still holds the latched op; writes leave rdata alone.
            if (bus.mem_read) begin
              if (owner_d) bus.d_rdata <= bus.mem_rdata;
              else         bus.i_rdata <= bus.mem_rdata;
            end
            if (owner_d) bus.d_ready <= 1'b1;
            else         bus.i_ready <= 1'b1;
            last_grant_i <= ~owner_d;
            state        <= DONE;
          end
        end
        DONE: begin
          bus.i_ready <= 1'b0;
          bus.d_ready <= 1'b0;
          grant       <= 2'b00;
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter sharing one 128-bit line-fill memory port between the instruction-side and data-side cache hierarchies. It latches one request at a time and drives it onto the memory interface (mem_read/mem_write/mem_addr/mem_wdata, one-cycle mem_ready pulse). It routes the returned line and a one-cycle ready pulse back to the granted requester. It sits between the two cache hierarchies and the main-memory model.

## Interface
- AW, 28: line address width (word address without 2-bit word offset).
- DW, 128: line data width (4 words).
- clk  in  1  single clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- i_read, i_write  in  1 each  I-side level requests, held until i_ready.
- i_addr  in  AW  I-side line address.
- i_wdata  in  DW  I-side write line.
- i_rdata  out  DW  I-side read line.
- i_ready  out  1  I-side one-cycle completion pulse.
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready  same as I-side, for the D-side.
- mem_read, mem_write  out  1 each  memory enables, held through the transaction.
- mem_addr  out  AW  latched line address.
- mem_wdata  out  DW  latched write line.
- mem_rdata  in  DW  memory read line, valid when mem_ready=1.
- mem_ready  in  1  one-cycle completion from memory.
- busy  out  1  high whenever state is not IDLE.
- grant  out  2  {d,i} one-hot owner of the current transaction; 00 in IDLE.

## Operation
- Reset is asynchronous and active-low. While reset_n=0, every register and output is 0: state=IDLE, mem_*, *_rdata, *_ready, busy, grant; last_grant=D.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - A requester is active if read|write.
  - No active requester: stay in IDLE.
  - Exactly one active: grant it.
  - Both active: tie-break per Configuration.
  - On grant: latch addr, wdata, op and owner. Set mem_read or mem_write, set grant, go to BUSY.
  - If a requester raises read and write together, it is treated as a write.
- BUSY:
  - mem_read/mem_write, mem_addr and mem_wdata are held constant from the latches.
  - On mem_ready=1: clear mem_read and mem_write. If op=read, capture mem_rdata into the owner's rdata register. Assert the owner's ready, update last_grant=owner, go to DONE.
- DONE:
  - Lasts exactly one cycle; the owner's ready is high.
  - The requester is required to drop its request on this edge.
  - Clear ready and grant, go to IDLE.
- i_rdata and d_rdata hold their last captured read line. Write completions do not modify them.
- mem_ready in IDLE or DONE is ignored.
- A request withdrawn during BUSY is still completed; ready is still pulsed.
- Changes to the non-granted requester's inputs during BUSY or DONE have no effect.
- Reset mid-transaction abandons the transaction, with no ready pulse. Requesters reissue after reset.

## Timing
- All outputs are registered.
- Request sampled in IDLE at edge T → mem_read/mem_write high from T+1.
- mem_ready sampled at edge T+k (k≥1) → owner ready high and mem_* low during the cycle after T+k.
- IDLE is re-entered at T+k+2. Minimum transaction: 3 cycles request-to-next-grant with mem_ready at k=1.
- The losing requester is granted no earlier than the edge after DONE, i.e. the next IDLE cycle.
- At most one ready pulse per transaction. i_ready and d_ready are never high in the same cycle.

## Configuration
- ARB_RR_EN defined: round-robin tie-break. On simultaneous requests in IDLE, grant the side opposite last_grant. After reset, last_grant=D, so I wins the first tie.
- ARB_RR_EN undefined: fixed priority, D-side always wins ties. last_grant is still maintained but does not affect the grant decision.

## Test plan
- Reset with request pending: hold d_read=1 and pulse reset_n=0 mid-BUSY → mem_read=0, grant=00, busy=0 immediately; no d_ready; after release, d_read is regranted on the next IDLE edge.
- Single read: i_read=1, i_addr=28'h0000123; memory returns 128'hDEAD…BEEF with mem_ready 3 cycles later → mem_addr=28'h0000123 held; i_rdata equals the line; exactly one i_ready pulse.
- Single write: d_write=1, d_addr=28'h00000A0, d_wdata=128'h1 → mem_write=1, mem_wdata=128'h1 held until mem_ready; d_ready pulses once; d_rdata unchanged.
- Simultaneous requests, both held through two transactions:
  - Without ARB_RR_EN: the first grant goes to D.
  - With ARB_RR_EN: I is granted first, then D, then I (alternating).
- read and write raised together: d_read=1 and d_write=1 in the same cycle → mem_write=1, mem_read=0.
- Stray mem_ready: pulse mem_ready in IDLE and in DONE → no state change, no extra ready pulse.
